// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the frame/data RAM arbiter and screen clients.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    function automatic int words_per_line(input int width, input int bpx);
        return 512 >> ($clog2(width) + bpx);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU load/store port of the RAM arbiter: request/ack handshake plus read return.
interface ram_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 11
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [WIDTH-1:0]  cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/ram_arbiter_screen_addr_gen.sv
// Combinational pixel-coordinate to framebuffer word address mapping.
module screen_addr_gen
    import ram_arb_pkg::*;
#(
    parameter int WIDTH                   = 16,
    parameter int ADDR_W                  = 11,
    parameter int RAM_SCREEN_OFFSET       = 1024,
    parameter int BITS_PER_MEMORY_PIXEL_X = 2,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 2
) (
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] vaddr
);
    localparam int WPL     = words_per_line(WIDTH, BITS_PER_MEMORY_PIXEL_X);
    localparam int X_SHIFT = $clog2(WIDTH) + BITS_PER_MEMORY_PIXEL_X;

    // Everything wraps modulo the RAM depth.
    assign vaddr = ADDR_W'(RAM_SCREEN_OFFSET)
                 + ADDR_W'(32'(pixel_y >> BITS_PER_MEMORY_PIXEL_Y) * WPL)
                 + ADDR_W'(pixel_x >> X_SHIFT);
endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video fetch priority with one-word pixel cache and CPU return path.
// Build option ARB_STARVE_GUARD_EN forces a CPU slot after MAX_VIDEO_STREAK contended video grants.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH                   = 16,
    parameter int REGISTER_COUNT          = 2048,
    parameter int RAM_SCREEN_OFFSET       = 1024,
    parameter int BITS_PER_MEMORY_PIXEL_X = 2,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 2,
    parameter int MAX_VIDEO_STREAK        = 4,
    localparam int ADDR_W                 = $clog2(REGISTER_COUNT)
) (
    input  logic              CPUclk,
    input  logic              rst,
    ram_arbiter_if.slave      cpu,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [WIDTH-1:0]  pixel_out,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);
    logic [ADDR_W-1:0] vaddr;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] inflight_addr;
    logic              valid;
    logic              inflight;
    logic [WIDTH-1:0]  pixel_q;
    logic              hit;
    logic              pending;
    logic              vreq;
    logic              force_cpu;
    logic              cpu_wr;
    owner_t            grant;
    owner_t            rd_own;

    screen_addr_gen #(
        .WIDTH                   (WIDTH),
        .ADDR_W                  (ADDR_W),
        .RAM_SCREEN_OFFSET       (RAM_SCREEN_OFFSET),
        .BITS_PER_MEMORY_PIXEL_X (BITS_PER_MEMORY_PIXEL_X),
        .BITS_PER_MEMORY_PIXEL_Y (BITS_PER_MEMORY_PIXEL_Y)
    ) u_addr_gen (
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .vaddr   (vaddr)
    );

    assign hit     = valid && (tag == vaddr);
    assign pending = inflight && (inflight_addr == vaddr);
    assign vreq    = !hit && !pending;

    always_comb begin
        grant = OWN_NONE;
        if (rst)
            grant = OWN_NONE;
        else if (vreq && !(cpu.cpu_req && force_cpu))
            grant = OWN_VID;
        else if (cpu.cpu_req)
            grant = OWN_CPU;
    end

    assign cpu_wr         = (grant == OWN_CPU) && cpu.cpu_we;
    assign mem_addr       = (grant == OWN_CPU) ? cpu.cpu_addr : vaddr;
    assign mem_we         = cpu_wr;
    assign mem_wdata      = cpu.cpu_wdata;
    assign cpu.cpu_ack    = (grant == OWN_CPU);
    assign cpu.cpu_rvalid = !rst && (rd_own == OWN_CPU);
    assign cpu.cpu_rdata  = mem_rdata;
    assign pixel_valid    = !rst && hit;
    assign pixel_out      = pixel_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_VIDEO_STREAK + 1);
    logic [STREAK_W-1:0] streak;

    assign force_cpu = (streak == STREAK_W'(MAX_VIDEO_STREAK));

    always_ff @(posedge CPUclk) begin
        if (rst)
            streak <= '0;
        else if (!cpu.cpu_req || grant == OWN_CPU)
            streak <= '0;
        else if (grant == OWN_VID && !force_cpu)
            streak <= streak + 1'b1;
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            rd_own        <= OWN_NONE;
            valid         <= 1'b0;
            tag           <= '0;
            pixel_q       <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            if (grant == OWN_CPU && !cpu.cpu_we)
                rd_own <= OWN_CPU;
            else if (grant == OWN_VID)
                rd_own <= OWN_VID;
            else
                rd_own <= OWN_NONE;

            // A CPU write to the returning address wins over the stale RAM word.
            if (rd_own == OWN_VID) begin
                tag      <= inflight_addr;
                valid    <= 1'b1;
                inflight <= 1'b0;
                pixel_q  <= (cpu_wr && cpu.cpu_addr == inflight_addr) ? cpu.cpu_wdata : mem_rdata;
            end else if (cpu_wr && valid && cpu.cpu_addr == tag) begin
                pixel_q <= cpu.cpu_wdata;
            end

            // A new fetch issued during a fill keeps the inflight flag set.
            if (grant == OWN_VID) begin
                inflight      <= 1'b1;
                inflight_addr <= vaddr;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a transaction-level reference model checked every cycle.
module tb_ram_arbiter;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 11;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CPUclk = 1'b0;
    logic rst    = 1'b1;
    always #5 CPUclk = ~CPUclk;

    ram_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) cpu_bus ();

    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [WIDTH-1:0]  pixel_out;
    logic              pixel_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    ram_arbiter dut (
        .CPUclk      (CPUclk),
        .rst         (rst),
        .cpu         (cpu_bus.slave),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    logic [15:0] ram [2048];
    logic [15:0] ref_ram [2048];

    always @(posedge CPUclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cached word, outstanding fetch, outstanding CPU read, streak.
    bit          m_valid, m_infl, m_vret, m_cret;
    int          m_tag, m_paddr, m_streak;
    logic [15:0] m_pix, m_pdata, m_cdata;

    always @(negedge CPUclk) begin : model
        int   va;
        int   g;
        bit   need, cw, m_hit;
        if (rst) begin
            check("rst_ack", 32'(cpu_bus.cpu_ack), 0);
            check("rst_rvalid", 32'(cpu_bus.cpu_rvalid), 0);
            check("rst_mem_we", 32'(mem_we), 0);
            check("rst_pix_valid", 32'(pixel_valid), 0);
            m_valid = 0; m_infl = 0; m_vret = 0; m_cret = 0;
            m_tag = 0; m_pix = 0; m_streak = 0;
        end else begin
            va    = (1024 + (int'(pixel_y) / 4) * 8 + int'(pixel_x) / 64) % 2048;
            m_hit = m_valid && (m_tag == va);
            need  = !m_hit && !(m_infl && m_paddr == va);
            if (need && !(cpu_bus.cpu_req && GUARD && m_streak == 4)) g = 2;
            else if (cpu_bus.cpu_req) g = 1;
            else g = 0;

            check("ack", 32'(cpu_bus.cpu_ack), 32'(g == 1));
            if (g != 0) begin
                check("mem_addr", 32'(mem_addr), (g == 1) ? 32'(cpu_bus.cpu_addr) : 32'(va));
                check("mem_we", 32'(mem_we), 32'(g == 1 && cpu_bus.cpu_we));
            end
            check("rvalid", 32'(cpu_bus.cpu_rvalid), 32'(m_cret));
            if (m_cret) check("rdata", 32'(cpu_bus.cpu_rdata), 32'(m_cdata));
            check("pix_valid", 32'(pixel_valid), 32'(m_hit));
            if (m_hit) check("pix_out", 32'(pixel_out), 32'(m_pix));

            cw = (g == 1) && cpu_bus.cpu_we;
            if (m_vret) begin
                m_tag   = m_paddr;
                m_valid = 1;
                m_infl  = 0;
                m_pix   = (cw && int'(cpu_bus.cpu_addr) == m_paddr) ? cpu_bus.cpu_wdata : m_pdata;
            end else if (cw && m_valid && int'(cpu_bus.cpu_addr) == m_tag) begin
                m_pix = cpu_bus.cpu_wdata;
            end
            m_vret = (g == 2);
            m_cret = (g == 1) && !cpu_bus.cpu_we;
            if (g == 2) begin
                m_infl  = 1;
                m_paddr = va;
                m_pdata = ref_ram[va];
            end
            if (m_cret) m_cdata = ref_ram[cpu_bus.cpu_addr];
            if (cw) ref_ram[cpu_bus.cpu_addr] = cpu_bus.cpu_wdata;
            if (!cpu_bus.cpu_req || g == 1) m_streak = 0;
            else if (g == 2 && m_streak < 4) m_streak++;
        end
    end

    task automatic step();
        @(posedge CPUclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CPUclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vid;
        bit acked;
        for (int i = 0; i < 2048; i++) begin
            ram[i]     = 16'(i) ^ 16'hA5A5;
            ref_ram[i] = 16'(i) ^ 16'hA5A5;
        end
        cpu_bus.cpu_req   = 0;
        cpu_bus.cpu_we    = 0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;
        pixel_x = '0;
        pixel_y = '0;

        step(); step();
        at_neg();
        check("reset_pixel_out", 32'(pixel_out), 0);
        check("reset_pixel_valid", 32'(pixel_valid), 0);

        // First video miss: (9>>2)*8 + (100>>6) + 1024 = 1041
        step();
        rst = 0; pixel_x = 10'd100; pixel_y = 10'd9;
        at_neg();
        check("miss_addr_c1", 32'(mem_addr), 32'd1041);
        check("miss_noack_c1", 32'(cpu_bus.cpu_ack), 0);
        step(); at_neg();
        check("miss_pv_c2", 32'(pixel_valid), 0);
        step(); at_neg();
        check("miss_pv_c3", 32'(pixel_valid), 1);
        check("miss_data_c3", 32'(pixel_out), 32'h0000A1B4);

        // CPU read of word 5, no video traffic
        step();
        cpu_bus.cpu_req = 1; cpu_bus.cpu_we = 0; cpu_bus.cpu_addr = 11'd5;
        at_neg();
        check("rd5_ack", 32'(cpu_bus.cpu_ack), 1);
        check("rd5_addr", 32'(mem_addr), 5);
        step();
        cpu_bus.cpu_req = 0;
        at_neg();
        check("rd5_rvalid", 32'(cpu_bus.cpu_rvalid), 1);
        check("rd5_rdata", 32'(cpu_bus.cpu_rdata), 32'h0000A5A0);

        // Snoop write to the cached word
        step();
        cpu_bus.cpu_req = 1; cpu_bus.cpu_we = 1; cpu_bus.cpu_addr = 11'd1041; cpu_bus.cpu_wdata = 16'hABCD;
        at_neg();
        check("snoop_ack", 32'(cpu_bus.cpu_ack), 1);
        check("snoop_we", 32'(mem_we), 1);
        step();
        cpu_bus.cpu_req = 0; cpu_bus.cpu_we = 0;
        at_neg();
        check("snoop_pix", 32'(pixel_out), 32'h0000ABCD);
        check("snoop_pv", 32'(pixel_valid), 1);

        // Write to the inflight address in the fill cycle
        step();
        pixel_x = 10'd0; pixel_y = 10'd0;
        at_neg();
        check("infl_vid_addr", 32'(mem_addr), 32'd1024);
        check("infl_vid_noack", 32'(cpu_bus.cpu_ack), 0);
        step();
        cpu_bus.cpu_req = 1; cpu_bus.cpu_we = 1; cpu_bus.cpu_addr = 11'd1024; cpu_bus.cpu_wdata = 16'h1234;
        at_neg();
        check("infl_wr_ack", 32'(cpu_bus.cpu_ack), 1);
        step();
        cpu_bus.cpu_req = 0; cpu_bus.cpu_we = 0;
        at_neg();
        check("infl_pv", 32'(pixel_valid), 1);
        check("infl_pix", 32'(pixel_out), 32'h00001234);

        // Continuous video misses with a CPU read held pending
        step();
        cpu_bus.cpu_req = 1; cpu_bus.cpu_we = 0; cpu_bus.cpu_addr = 11'd7;
        pixel_x = 10'd64;
        vid = 0; acked = 0;
        for (int i = 0; i < 12 && !acked; i++) begin
            at_neg();
            if (cpu_bus.cpu_ack) acked = 1;
            else if (int'(mem_addr) == 1024 + int'(pixel_x) / 64) vid++;
            step();
            if (!acked && i < 7) pixel_x = pixel_x + 10'd64;
        end
        cpu_bus.cpu_req = 0;
        check("starve_acked", 32'(acked), 1);
        check("starve_vid_grants", 32'(vid), GUARD ? 32'd4 : 32'd8);
        at_neg();
        check("starve_rvalid", 32'(cpu_bus.cpu_rvalid), 1);
        check("starve_rdata", 32'(cpu_bus.cpu_rdata), 32'h0000A5A2);

        // Reset landing on a pending CPU read return
        for (int i = 0; i < 4; i++) step();
        at_neg();
        check("pre_rst_pv", 32'(pixel_valid), 1);
        step();
        cpu_bus.cpu_req = 1; cpu_bus.cpu_we = 0; cpu_bus.cpu_addr = 11'd9;
        at_neg();
        check("rst_rd_ack", 32'(cpu_bus.cpu_ack), 1);
        step();
        cpu_bus.cpu_req = 0; rst = 1;
        at_neg();
        check("rst_rd_rvalid", 32'(cpu_bus.cpu_rvalid), 0);
        check("rst_rd_pv", 32'(pixel_valid), 0);
        step();
        at_neg();
        check("rst_rd_pix", 32'(pixel_out), 0);
        step();
        rst = 0;
        at_neg();
        check("post_rst_rvalid", 32'(cpu_bus.cpu_rvalid), 0);
        check("post_rst_pv", 32'(pixel_valid), 0);
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
